// File: rtl/mdu_sequencer_if.sv
// Issue/result bundle between the E stage and the multiply/divide sequencer.
interface mdu_sequencer_if;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        md_use_d;
   logic        busy;
   logic        stall_d;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, md_op, src_a, src_b, md_use_d,
      input  busy, stall_d, hi, lo
   );

   modport slave (
      input  start, md_op, src_a, src_b, md_use_d,
      output busy, stall_d, hi, lo
   );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer: one-shot compute, fixed-latency commit.
// Define MDU_MADD_EN to enable md_op 7 (madd: {hi,lo} += signed a*b).
module mdu_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic            clk,
   input logic            reset,
   mdu_sequencer_if.slave bus
);
   localparam int unsigned CNT_W = 4;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MDU_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'd7;
`endif

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             commit_q, commit_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      res_hi_q, res_hi_d;
   logic [31:0]      res_lo_q, res_lo_d;

   logic signed [63:0] a_sx, b_sx, prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] dvs_s, quo_s, rem_s;
   logic [31:0]        dvs_u, quo_u, rem_u;
   logic [63:0]        res_c;
   logic               is_multi_c, is_div_c, div_zero_c, div_ovf_c;

   // One-shot arithmetic; a zero divisor is replaced so the divider stays defined.
   always_comb begin
      a_sx       = {{32{bus.src_a[31]}}, bus.src_a};
      b_sx       = {{32{bus.src_b[31]}}, bus.src_b};
      prod_s     = a_sx * b_sx;
      prod_u     = {32'd0, bus.src_a} * {32'd0, bus.src_b};
      div_zero_c = (bus.src_b == 32'd0);
      div_ovf_c  = (bus.src_a == 32'h8000_0000) && (bus.src_b == 32'hFFFF_FFFF);
      dvs_s      = div_zero_c ? 32'sd1 : $signed(bus.src_b);
      dvs_u      = div_zero_c ? 32'd1 : bus.src_b;
      if (div_ovf_c) begin
         quo_s = 32'sh8000_0000;
         rem_s = 32'sd0;
      end else begin
         quo_s = $signed(bus.src_a) / dvs_s;
         rem_s = $signed(bus.src_a) % dvs_s;
      end
      quo_u = bus.src_a / dvs_u;
      rem_u = bus.src_a % dvs_u;
   end

   always_comb begin
      res_c      = '0;
      is_multi_c = 1'b0;
      is_div_c   = 1'b0;
      case (bus.md_op)
         OP_MULT:  begin res_c = prod_s;                          is_multi_c = 1'b1; end
         OP_MULTU: begin res_c = prod_u;                          is_multi_c = 1'b1; end
         OP_DIV:   begin res_c = {rem_s, quo_s}; is_div_c = 1'b1; is_multi_c = 1'b1; end
         OP_DIVU:  begin res_c = {rem_u, quo_u}; is_div_c = 1'b1; is_multi_c = 1'b1; end
`ifdef MDU_MADD_EN
         OP_MADD:  begin res_c = {hi_q, lo_q} + prod_s;           is_multi_c = 1'b1; end
`endif
         default:  ;
      endcase
   end

   // Sequencer: latch result at issue, count down, commit when the counter hits zero.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      commit_d = commit_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      if (state_q == S_IDLE) begin
         if (bus.start) begin
            if (is_multi_c) begin
               state_d  = S_RUN;
               busy_d   = 1'b1;
               res_hi_d = res_c[63:32];
               res_lo_d = res_c[31:0];
               commit_d = !(is_div_c && div_zero_c);
               cnt_d    = is_div_c ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            end else if (bus.md_op == OP_MTHI) begin
               hi_d = bus.src_a;
            end else if (bus.md_op == OP_MTLO) begin
               lo_d = bus.src_a;
            end
         end
      end else begin
         if (cnt_q == '0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (commit_q) begin
               hi_d = res_hi_q;
               lo_d = res_lo_q;
            end
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         commit_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         commit_q <= commit_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.stall_d = bus.md_use_d & (busy_q | (bus.start & is_multi_c));
endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized and directed bench for mdu_sequencer against an arithmetic reference model.
module tb_mdu_sequencer;
   localparam int unsigned MULT_LAT = 5;
   localparam int unsigned DIV_LAT  = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mdu_sequencer_if bus();

   mdu_sequencer #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: architectural HI/LO, pending result and the edge on which it lands.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          m_busy, p_valid;
   int          edge_n, commit_at;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic bit multi_op(input logic [2:0] op);
      case (op)
         3'd1, 3'd2, 3'd3, 3'd4: return 1'b1;
`ifdef MDU_MADD_EN
         3'd7: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      longint      sq, sr;
      logic [63:0] r64;
      sa = a;
      sb = b;
      r64 = '0;
      p_valid = 1'b1;
      case (op)
         3'd1: r64 = 64'(longint'(sa) * longint'(sb));
         3'd2: r64 = 64'(longint'(unsigned'(a)) * longint'(unsigned'(b)));
         3'd3: if (b == 0) p_valid = 1'b0;
               else begin
                  sq = longint'(sa) / longint'(sb);
                  sr = longint'(sa) % longint'(sb);
                  r64 = {32'(sr), 32'(sq)};
               end
         3'd4: if (b == 0) p_valid = 1'b0;
               else r64 = {a % b, a / b};
`ifdef MDU_MADD_EN
         3'd7: r64 = {m_hi, m_lo} + 64'(longint'(sa) * longint'(sb));
`endif
         default: ;
      endcase
      p_hi = r64[63:32];
      p_lo = r64[31:0];
      m_busy = 1'b1;
      commit_at = edge_n + ((op == 3'd3 || op == 3'd4) ? int'(DIV_LAT) : int'(MULT_LAT));
   endtask

   // One clock: drive at negedge, check stall, advance model at posedge, check registered outputs.
   task automatic step(input bit st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit use_d, input bit r);
      bit exp_stall;
      bus.start = st; bus.md_op = op; bus.src_a = a; bus.src_b = b; bus.md_use_d = use_d; rst = r;
      #1;
      exp_stall = use_d && (m_busy || (st && multi_op(op)));
      chk("stall_d", 32'(bus.stall_d), 32'(exp_stall));
      @(posedge clk);
      edge_n++;
      if (r) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; p_valid = 1'b0;
      end else if (m_busy) begin
         if (edge_n == commit_at) begin
            if (p_valid) begin m_hi = p_hi; m_lo = p_lo; end
            m_busy = 1'b0;
         end
      end else if (st) begin
         if (op == 3'd5) m_hi = a;
         else if (op == 3'd6) m_lo = a;
         else if (multi_op(op)) model_issue(op, a, b);
      end
      @(negedge clk);
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
   endtask

   task automatic idle(input int n, input bit use_d);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, use_d, 1'b0);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      step(1'b1, op, a, b, 1'b1, 1'b0);
   endtask

   initial begin
      m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
      m_busy = 1'b0; p_valid = 1'b0; edge_n = 0; commit_at = 0;
      bus.start = 1'b0; bus.md_op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.md_use_d = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("rst_hi_lit", bus.hi, 32'h0);
      chk("rst_lo_lit", bus.lo, 32'h0);
      chk("rst_busy_lit", 32'(bus.busy), 32'h0);

      idle(2, 1'b1);
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      idle(MULT_LAT, 1'b1);
      chk("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo_lit", bus.lo, 32'hFFFF_FFFA);

      issue(3'd2, 32'hFFFF_FFFE, 32'd3);
      idle(MULT_LAT, 1'b0);
      chk("multu_hi_lit", bus.hi, 32'h0000_0002);
      chk("multu_lo_lit", bus.lo, 32'hFFFF_FFFA);

      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      idle(DIV_LAT, 1'b1);
      chk("div_hi_lit", bus.hi, 32'hFFFF_FFFF);
      chk("div_lo_lit", bus.lo, 32'hFFFF_FFFD);

      step(1'b1, 3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
      step(1'b1, 3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
      issue(3'd4, 32'd7, 32'd0);
      idle(DIV_LAT, 1'b1);
      chk("divz_hi_lit", bus.hi, 32'h11);
      chk("divz_lo_lit", bus.lo, 32'h22);

      step(1'b1, 3'd5, 32'hABCD, 32'd0, 1'b1, 1'b0);
      chk("mthi_lit", bus.hi, 32'hABCD);
      chk("mthi_busy_lit", 32'(bus.busy), 32'h0);

      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(DIV_LAT, 1'b0);
      chk("ovf_hi_lit", bus.hi, 32'h0);
      chk("ovf_lo_lit", bus.lo, 32'h8000_0000);

      issue(3'd1, 32'd5, 32'd6);
      idle(1, 1'b1);
      step(1'b1, 3'd6, 32'hDEAD, 32'd0, 1'b1, 1'b0);
      idle(MULT_LAT - 2, 1'b1);
      chk("ignored_mtlo_lit", bus.lo, 32'd30);

      // Back-to-back issue right after busy falls, then abort it with reset.
      issue(3'd1, 32'd9, 32'd9);
      idle(2, 1'b0);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("abort_busy_lit", 32'(bus.busy), 32'h0);
      chk("abort_hi_lit", bus.hi, 32'h0);
      idle(8, 1'b0);
      chk("abort_lo_lit", bus.lo, 32'h0);

`ifdef MDU_MADD_EN
      step(1'b1, 3'd5, 32'h0, 32'd0, 1'b0, 1'b0);
      step(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      issue(3'd7, 32'd1, 32'd1);
      idle(MULT_LAT, 1'b0);
      chk("madd_hi_lit", bus.hi, 32'h1);
      chk("madd_lo_lit", bus.lo, 32'h0);
`endif

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] a, b;
         int sel;
         a = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) b = 32'hFFFF_FFFF;
         else if (sel == 2) b = 32'($urandom_range(1, 9));
         else b = $urandom;
         if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
         step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, b,
              $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the pipelined MIPS core, located in the E stage next to the ALU.
- Accepts one HI/LO-class operation per issue and computes the result in one shot.
- Holds the result internally for a fixed latency, then commits it to the architectural HI/LO registers.
- Drives `busy` and a decode-stage stall request so the hazard logic can hold any later multiply/divide or mfhi/mflo instruction.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  E-stage operation valid this cycle
- md_op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd (feature only)
- src_a  input  32  rs value, already forwarded
- src_b  input  32  rt value, already forwarded
- md_use_d  input  1  instruction in D stage is any md_op or mfhi/mflo
- busy  output  1  a multi-cycle operation is in flight
- stall_d  output  1  stall request to the hazard unit
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset state: state IDLE, counter 0, busy 0, hi 0, lo 0, internal result registers 0. A reset asserted mid-operation aborts the operation, and the pending result is discarded.
- States:
  - IDLE: no operation in flight.
  - RUN: a multi-cycle operation is in flight.
- Acceptance: start is acted on only in IDLE. start arriving in RUN is ignored; the hazard unit guarantees this never happens, and the bench checks that HI/LO are not corrupted if it does.
- mult/multu/div/divu/madd sampled at edge N:
  - Result is computed combinationally from src_a/src_b and latched at edge N.
  - Counter loads latency-1; state goes to RUN; busy is 1 after edge N.
  - Counter decrements every cycle in RUN.
  - At the edge where the counter is 0, the latched result is written to hi/lo, state returns to IDLE and busy goes to 0.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles, and hi/lo change at edge N+latency.
- Arithmetic:
  - mult: signed 32x32 to 64, hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64, same split.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned; same outputs.
- Divide by zero (src_b==0): the full DIV_CYCLES busy sequence still runs, but hi/lo are left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo in IDLE: hi (or lo) <= src_a at the same edge; busy stays 0.
- md_op 0, or 7 without the feature: no effect.
- stall_d = md_use_d & (busy | (start & md_op is a multi-cycle op)). Purely combinational.
- Back-to-back: a new multi-cycle op may start on the edge immediately after busy falls.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: md_op 7 = madd. Computes {hi,lo} + signed(src_a)*signed(src_b), modulo 2^64, using the hi/lo values current at issue. Latency is MULT_CYCLES.
- Undefined: md_op 7 is treated as none, and no 64-bit adder is present.

Test Plan:
- mult src_a=0xFFFFFFFE (-2), src_b=3 at edge N:
  - busy is 1 for 5 cycles;
  - at N+5, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with the same operands:
  - at N+5, hi=0x00000002, lo=0xFFFFFFFA.
- div -7 / 2 at edge N:
  - busy is 1 for 10 cycles;
  - at N+10, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 7 / 0 with prior hi=0x11, lo=0x22:
  - busy runs 10 cycles;
  - hi/lo stay 0x11/0x22.
- Busy and stall behaviour:
  - md_use_d=1 during busy gives stall_d=1; md_use_d=1 with no activity gives stall_d=0.
  - mthi 0xABCD in IDLE: hi=0xABCD at the next edge, busy stays 0.
  - start with mtlo during RUN: ignored, lo unchanged.
- Reset and madd:
  - reset asserted at cycle 3 of a mult: busy=0, hi=lo=0 next cycle, and no commit afterwards.
  - With MDU_MADD_EN, hi=0, lo=0xFFFFFFFF, madd 1*1: at N+5, hi=1, lo=0.
